// File: rtl/first_one_iterator.sv
// rtl/first_one_iterator.sv - emits each set bit of an accepted vector, lowest index first, one beat per cycle
// Optional beat-remaining counter port enabled by FIRST_ONE_ITERATOR_COUNT_EN.
module first_one_iterator #(
  parameter int WIDTH = 8,
  localparam int INDEX_WIDTH = $clog2(WIDTH),
  localparam int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [WIDTH-1:0]       output_first_one,
  output logic [INDEX_WIDTH-1:0] output_index,
  output logic                   output_last,
  output logic                   output_valid,
  input  logic                   output_ready
`ifdef FIRST_ONE_ITERATOR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] output_remaining
`endif
);

  typedef enum logic {
    IDLE,
    ITERATE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] lowest;
  logic             load;
  logic             advance;

  assign lowest           = pending & (~pending + 1'b1);
  assign output_valid     = (pending != '0);
  assign output_first_one = lowest;
  assign output_last      = output_valid && ((pending & (pending - 1'b1)) == '0);
  assign advance          = output_valid && output_ready;
  assign input_ready      = (state == IDLE) || (advance && output_last);
  assign load             = input_valid && input_ready;

  always_comb begin
    output_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lowest[i]) output_index = i[INDEX_WIDTH-1:0];
    end
  end

  // A load in the same cycle as the final beat replaces the drained vector with no bubble.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    if (load) begin
      pending_next = input_data;
      state_next   = (input_data != '0) ? ITERATE : IDLE;
    end else if (advance) begin
      pending_next = pending & ~lowest;
      if (output_last) state_next = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

`ifdef FIRST_ONE_ITERATOR_COUNT_EN
  logic [COUNT_WIDTH-1:0] load_count;
  logic [COUNT_WIDTH-1:0] remaining;

  always_comb begin
    load_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_count = load_count + {{(COUNT_WIDTH-1){1'b0}}, input_data[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_count;
    end else if (advance) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign output_remaining = remaining;
`endif

endmodule

// File: tb/tb_first_one_iterator.sv
// tb/tb_first_one_iterator.sv - randomized and directed checks against a queue-of-indices reference model
module tb_first_one_iterator;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_first_one;
  logic [2:0]       output_index;
  logic             output_last;
  logic             output_valid;
  logic             output_ready;
`ifdef FIRST_ONE_ITERATOR_COUNT_EN
  logic [3:0]       output_remaining;
`endif

  first_one_iterator #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .input_data(input_data),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .output_first_one(output_first_one),
    .output_index(output_index),
    .output_last(output_last),
    .output_valid(output_valid),
    .output_ready(output_ready)
`ifdef FIRST_ONE_ITERATOR_COUNT_EN
    ,
    .output_remaining(output_remaining)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The model holds the indices still to be emitted for the current vector, in order.
  task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    logic exp_valid;
    logic exp_last;
    logic exp_ir;
    int   exp_idx;
    @(negedge clock);
    reset        = rst;
    input_valid  = v;
    input_data   = d;
    output_ready = rdy;
    #1;
    exp_valid = (q.size() != 0);
    exp_idx   = exp_valid ? q[0] : 0;
    exp_last  = (q.size() == 1);
    exp_ir    = !exp_valid || (rdy && exp_last);
    check("output_valid", 32'(output_valid), 32'(exp_valid));
    check("output_first_one", 32'(output_first_one), exp_valid ? (32'd1 << exp_idx) : 32'd0);
    check("output_index", 32'(output_index), 32'(exp_idx));
    check("output_last", 32'(output_last), 32'(exp_last));
    check("input_ready", 32'(input_ready), 32'(exp_ir));
`ifdef FIRST_ONE_ITERATOR_COUNT_EN
    check("output_remaining", 32'(output_remaining), 32'(q.size()));
`endif
    if (output_valid && output_ready) beats++;
    if (rst) begin
      q.delete();
    end else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (v && exp_ir) begin
        q.delete();
        for (int i = 0; i < WIDTH; i++) if (d[i]) q.push_back(i);
      end
    end
    @(posedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < WIDTH + 1; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (2) @(posedge clock);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'b1010_0100, 1'b1);
    drain();

    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h81, 1'b1);
    drain();

    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, (i % 2) == 0);
    drain();

    step(1'b0, 1'b1, 8'b0000_0001, 1'b1);
    step(1'b0, 1'b1, 8'b1000_0000, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    drain();

    step(1'b0, 1'b1, 8'b0001_1000, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    step(1'b0, 1'b1, 8'b0110_1001, 1'b1);
    drain();

    for (int v = 0; v < 256; v++) begin
      beats = 0;
      step(1'b0, 1'b1, 8'(v), 1'b1);
      drain();
      check("beat_count", 32'(beats), 32'($countones(8'(v))));
    end

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
